// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the sized RV32 data memory.
// Pairs with data_mem_sized; the optional clear sweep is enabled by DATA_MEM_CLEAR_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'h0;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = 4'b0011 << lane;
      SZ_W:    be = 4'b1111;
      default: be = 4'h0;
    endcase
    return be;
  endfunction

  // The addressed lane is shifted to bit 0 before extension, so the lane
  // only matters for byte and half accesses.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane, input logic unsigned_flag);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {lane, 3'b000};
    res = word;
    case (size)
      SZ_B:    res = unsigned_flag ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    res = unsigned_flag ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Request-side decode: alignment/range/size checking, byte enables and
// lane-replicated store data for the sized data memory.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic [31:0]       wdata,
  output logic              err,
  output logic [3:0]        be,
  output logic [31:0]       wdata_rep,
  output logic [IDX_W-1:0]  idx
);

  logic out_of_range;
  logic misaligned;
  logic bad_size;

  // Any address bit above the word index means the byte address is past the array.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign out_of_range = |addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign idx = addr[2 +: IDX_W];

  always_comb begin
    bad_size   = (size == 2'b11);
    misaligned = ((size == SZ_H) && addr[0]) ||
                 ((size == SZ_W) && (addr[1:0] != 2'b00));
    err        = bad_size || misaligned || out_of_range;
    be         = err ? 4'h0 : be_gen(size, addr[1:0]);
  end

  always_comb begin
    wdata_rep = wdata;
    case (size)
      SZ_B:    wdata_rep = {4{wdata[7:0]}};
      SZ_H:    wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Parametrised RV32 data memory with valid/ready request/response and sized loads/stores.
// Define DATA_MEM_CLEAR_EN to zero the array after every reset before accepting requests.
module data_mem_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];

  logic             a_err;
  logic [3:0]       a_be;
  logic [31:0]      a_wdata;
  logic [IDX_W-1:0] a_idx;

  logic             running;
  logic             clearing;
  logic [IDX_W-1:0] clr_idx;

  logic             accept;
  logic [3:0]       wr_be;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;

  logic [31:0]      rd_word;
  logic             load_ok_q;
  logic [1:0]       size_q;
  logic [1:0]       lane_q;
  logic             uns_q;

  dmem_align #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W)
  ) u_align (
    .addr      (req_addr),
    .size      (req_size),
    .wdata     (req_wdata),
    .err       (a_err),
    .be        (a_be),
    .wdata_rep (a_wdata),
    .idx       (a_idx)
  );

`ifdef DATA_MEM_CLEAR_EN
  state_e           state;
  state_e           state_nxt;
  logic [IDX_W-1:0] clr_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state == ST_CLEAR) && (clr_cnt == {IDX_W{1'b1}})) state_nxt = ST_RUN;
  end

  always_comb begin
    running  = (state == ST_RUN);
    clearing = (state == ST_CLEAR);
    clr_idx  = clr_cnt;
  end
`else
  assign running  = 1'b1;
  assign clearing = 1'b0;
  assign clr_idx  = '0;
`endif

  // Single-entry response buffer: a new request may land while the old response drains.
  assign req_ready = running && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    wr_be   = 4'h0;
    wr_idx  = a_idx;
    wr_data = a_wdata;
    if (clearing) begin
      wr_be   = 4'hF;
      wr_idx  = clr_idx;
      wr_data = '0;
    end else if (accept && req_we && !a_err) begin
      wr_be = a_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !req_we) rd_word <= mem[a_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      load_ok_q <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      uns_q     <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= a_err;
      load_ok_q <= !req_we && !a_err;
      size_q    <= req_size;
      lane_q    <= req_addr[1:0];
      uns_q     <= req_unsigned;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      load_ok_q <= 1'b0;
    end
  end

  // Stores and errored requests report zero data; rd_word is never reset, so gate it.
  assign rsp_rdata = load_ok_q ? load_ext(rd_word, size_q, lane_q, uns_q) : 32'h0;

endmodule

// File: tb/tb_data_mem_sized.sv
// Scoreboard bench for data_mem_sized; the clear-after-reset steps run when DATA_MEM_CLEAR_EN is defined.
module tb_data_mem_sized;
  import dmem_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  data_mem_sized #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one request (called at posedge+1), wait for its handshake, push the expected response.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", {31'h0, req_ready}, 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end else begin
      sb_q.push_back({exp_err, exp_rdata});
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("rsp_latency", {31'h0, rsp_valid}, 32'h1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("drain_empty", sb_q.size(), 32'h0);
  endtask

  // Compare each delivered response against the oldest queued expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e[31:0]);
        checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
      end
    end
  end

  initial begin
    int n;
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = SZ_W;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;
    #1;
    checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
`ifdef DATA_MEM_CLEAR_EN
    checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h0);
`else
    checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h1);
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
`ifdef DATA_MEM_CLEAR_EN
    n = 0;
    while (!req_ready && n < DEPTH + 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("clear_cycles_initial", n, DEPTH);
`endif
    $display("[TB] word store/load");
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    $display("[TB] byte store/loads");
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
    applyStimulus(1'b1, SZ_B, 1'b0, 32'h13, 32'hFFFFFF80, 32'h0, 1'b0);
    applyStimulus(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    applyStimulus(1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h80223344, 1'b0);
    applyStimulus(1'b0, SZ_B, 1'b0, 32'h12, 32'h0, 32'h00000022, 1'b0);
    applyStimulus(1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'h00003344, 1'b0);

    $display("[TB] half store/loads and misalignment");
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0);
    applyStimulus(1'b1, SZ_H, 1'b0, 32'h22, 32'h0000BEEF, 32'h0, 1'b0);
    applyStimulus(1'b0, SZ_H, 1'b0, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0);
    applyStimulus(1'b0, SZ_H, 1'b1, 32'h22, 32'h0, 32'h0000BEEF, 1'b0);
    applyStimulus(1'b0, SZ_H, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h21, 32'hCAFEF00D, 32'h0, 1'b1);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hBEEF5678, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
    drain();

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h80223344, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SZ_H;
    req_unsigned = 1'b1;
    req_addr  = 32'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_req_ready", {31'h0, req_ready}, 32'h0);
      checkOutput("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      checkOutput("stall_rsp_rdata", rsp_rdata, 32'h80223344);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    applyStimulus(1'b0, SZ_H, 1'b1, 32'h22, 32'h0, 32'h0000BEEF, 1'b0);
    drain();

    $display("[TB] range and back-to-back");
    applyStimulus(1'b0, SZ_W, 1'b0, 4*DEPTH, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, SZ_W, 1'b0, 4*DEPTH - 4, 32'hA5A5_0F0F, 32'h0, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 4*DEPTH - 4, 32'h0, 32'hA5A50F0F, 1'b0);
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h8, 32'h0BADF00D, 32'h0, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h8, 32'h0, 32'h0BADF00D, 1'b0);
    drain();

`ifdef DATA_MEM_CLEAR_EN
    $display("[TB] reset during traffic clears the array");
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h30, 32'h55AA55AA, 32'h0, 1'b0);
    drain();
    rsp_ready = 1'b0;
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h30, 32'h0, 32'h55AA55AA, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    sb_q.delete();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("clear_req_ready_low", {31'h0, req_ready}, 32'h0);
    n = 0;
    while (!req_ready && n < DEPTH + 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("clear_cycles", n, DEPTH);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
